// File: rtl/key_flash_pkg.sv
// Shared types and default timing constants for the key-driven flash control front end.
package key_flash_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;
  localparam int unsigned TIMEOUT_S   = 10;

  localparam int unsigned DEF_DEBOUNCE_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DEF_TIMEOUT_CYC  = CLK_HZ * TIMEOUT_S;

endpackage

// File: rtl/key_flash_if.sv
// Button input and flash-control outputs bundled between the board side and the controller.
interface key_flash_if;
  logic key_n;
  logic press_pulse;
  logic flash_en;

  modport master (output key_n, input press_pulse, input flash_en);
  modport slave  (input key_n, output press_pulse, output flash_en);
endinterface

// File: rtl/key_debounce.sv
// Push-button synchroniser and debounce FSM; emits a registered one-cycle strobe per qualified press.
module key_debounce
  import key_flash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_DB_PRESS   = DB_PRESS;
  localparam logic [1:0] ST_HELD       = HELD;
  localparam logic [1:0] ST_DB_RELEASE = DB_RELEASE;

  logic [1:0]    sync_reg;
  logic          key_s;
  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pulse_reg, pulse_next;

  assign key_s = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!key_s) begin
          state_next = ST_DB_PRESS;
          cnt_next   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (key_s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_HELD;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HELD: begin
        if (key_s) begin
          state_next = ST_DB_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_DB_RELEASE: begin
        // Release qualification only returns to IDLE; it never strobes.
        if (!key_s) begin
          state_next = ST_HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], key_n};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  assign press_pulse = pulse_reg;

endmodule

// File: rtl/key_flash_ctrl.sv
// Button front end for the LED flasher: each debounced press toggles flash_en, with optional auto-off.
module key_flash_ctrl
  import key_flash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic        sys_clk,
  input  logic        rst,
  key_flash_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic          db_pulse;
  logic          press_pulse_reg;
  logic          flash_en_reg, flash_en_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          expire;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .key_n       (bus.key_n),
    .press_pulse (db_pulse)
  );

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_tmo
      assign expire = 1'b0;
    end else begin : g_tmo
      assign expire = flash_en_reg && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
    end
  endgenerate

  // A press coinciding with expiry toggles an enabled output off, which matches expiry.
  always_comb begin
    flash_en_next = flash_en_reg;
    tmo_cnt_next  = '0;
    if (db_pulse) begin
      flash_en_next = ~flash_en_reg;
    end else if (expire) begin
      flash_en_next = 1'b0;
    end else if (flash_en_reg && (TIMEOUT_CYC != 0)) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      press_pulse_reg <= 1'b0;
      flash_en_reg    <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      press_pulse_reg <= db_pulse;
      flash_en_reg    <= flash_en_next;
      tmo_cnt_reg     <= tmo_cnt_next;
    end
  end

  assign bus.press_pulse = press_pulse_reg;
  assign bus.flash_en    = flash_en_reg;

endmodule

// File: tb/tb_key_flash_ctrl.sv
// Randomised and directed checks of key_flash_ctrl against a run-length behavioural model.
module tb_key_flash_ctrl;

  localparam int D = 8;
  localparam int T = 100;

  logic sys_clk = 1'b0;
  logic rst;
  key_flash_if bus();

  key_flash_ctrl #(
    .DEBOUNCE_CYC (D),
    .TIMEOUT_CYC  (T)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Model: key_s is key_n delayed two edges; the debounced level flips after
  // D+1 consecutive disagreeing samples, a flip to pressed emits a strobe one edge later.
  logic m_kd1, m_kd2, m_deb, m_ipulse, m_pulse, m_flash;
  int   m_run, m_on;

  int edge_idx, pulse_cnt, last_pulse_edge, flash_hi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic k, input logic r);
    logic sample;
    if (r) begin
      m_kd1 = 1'b1; m_kd2 = 1'b1; m_deb = 1'b0; m_run = 0;
      m_ipulse = 1'b0; m_pulse = 1'b0; m_flash = 1'b0; m_on = 0;
    end else begin
      sample = m_kd2;
      m_kd2  = m_kd1;
      m_kd1  = k;
      m_pulse = m_ipulse;
      if (m_ipulse) begin
        m_flash = ~m_flash;
        m_on    = m_flash ? 1 : 0;
      end else if (m_flash) begin
        if (m_on == T) begin
          m_flash = 1'b0;
          m_on    = 0;
        end else begin
          m_on++;
        end
      end
      m_ipulse = 1'b0;
      if ((!sample) != m_deb) begin
        m_run++;
        if (m_run == D + 1) begin
          m_deb    = ~m_deb;
          m_run    = 0;
          m_ipulse = m_deb;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic k, input logic r);
    bus.key_n = k;
    rst       = r;
    @(posedge sys_clk);
    model_edge(k, r);
    #1;
    check("press_pulse", 32'(bus.press_pulse), 32'(m_pulse));
    check("flash_en", 32'(bus.flash_en), 32'(m_flash));
    if (bus.press_pulse) begin
      pulse_cnt++;
      last_pulse_edge = edge_idx;
    end
    if (bus.flash_en) flash_hi++;
    edge_idx++;
  endtask

  task automatic begin_scn();
    edge_idx = 0; pulse_cnt = 0; last_pulse_edge = -1; flash_hi = 0;
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
  endtask

  initial begin
    bus.key_n = 1'b1;
    rst       = 1'b1;

    // Reset behaviour with the key released
    begin_scn();
    repeat (3) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    check("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
    check("rst_flash_en", 32'(bus.flash_en), 32'd0);
    $display("scenario reset: pulses=%0d flash_en=%0b", pulse_cnt, bus.flash_en);

    // Clean press
    begin_scn();
    repeat (30) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    check("clean_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("clean_pulse_edge", 32'(last_pulse_edge), 32'd11);
    check("clean_flash_en", 32'(bus.flash_en), 32'd1);
    $display("scenario clean press: pulses=%0d edge=%0d flash_en=%0b", pulse_cnt, last_pulse_edge, bus.flash_en);

    // Bounced press: final falling edge at edge 7
    do_reset(2);
    begin_scn();
    repeat (5) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    check("bounce_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("bounce_pulse_edge", 32'(last_pulse_edge), 32'd18);
    check("bounce_flash_en", 32'(bus.flash_en), 32'd1);
    $display("scenario bounce press: pulses=%0d edge=%0d flash_en=%0b", pulse_cnt, last_pulse_edge, bus.flash_en);

    // Toggle off, then a release with three 2-cycle glitches
    begin_scn();
    repeat (20) step(1'b0, 1'b0);
    repeat (3) begin
      repeat (2) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
    end
    repeat (20) step(1'b1, 1'b0);
    check("toggle_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("toggle_pulse_edge", 32'(last_pulse_edge), 32'd11);
    check("toggle_flash_en", 32'(bus.flash_en), 32'd0);
    $display("scenario toggle off: pulses=%0d edge=%0d flash_en=%0b", pulse_cnt, last_pulse_edge, bus.flash_en);

    // Auto-off, second press strobes exactly on the expiry edge (111)
    begin_scn();
    repeat (20) step(1'b0, 1'b0);
    repeat (80) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    repeat (120) step(1'b1, 1'b0);
    check("autooff_pulse_cnt", 32'(pulse_cnt), 32'd2);
    check("autooff_last_edge", 32'(last_pulse_edge), 32'd111);
    check("autooff_hi_cycles", 32'(flash_hi), 32'd100);
    check("autooff_flash_en", 32'(bus.flash_en), 32'd0);
    $display("scenario auto-off: pulses=%0d high_cycles=%0d flash_en=%0b", pulse_cnt, flash_hi, bus.flash_en);

    // Reset while debouncing (counter at 5), key held low throughout
    do_reset(2);
    begin_scn();
    repeat (8) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("midrst_pulse", 32'(bus.press_pulse), 32'd0);
    check("midrst_flash_en", 32'(bus.flash_en), 32'd0);
    begin_scn();
    repeat (20) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    check("midrst_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("midrst_pulse_edge", 32'(last_pulse_edge), 32'd11);
    check("midrst_flash_en_after", 32'(bus.flash_en), 32'd1);
    $display("scenario reset mid-debounce: pulses=%0d edge=%0d flash_en=%0b", pulse_cnt, last_pulse_edge, bus.flash_en);

    // Random key activity with occasional resets
    do_reset(2);
    begin_scn();
    begin
      int   left;
      logic lv;
      left = 3000;
      lv   = 1'b1;
      while (left > 0) begin
        int run_len;
        run_len = int'($urandom_range(1, 14));
        lv = ~lv;
        for (int i = 0; i < run_len && left > 0; i++) begin
          step(lv, $urandom_range(0, 299) == 0);
          left--;
        end
      end
    end
    $display("scenario random: cycles=%0d pulses=%0d", edge_idx, pulse_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_flash_ctrl.md
Name: key_flash_ctrl

Overview:
Front-end control stage for the LED flasher. It samples the board push button, synchronises and debounces it, and produces a one-cycle press pulse. Each qualified press toggles a registered flash-enable level, which drives the flasher's valid/enable input directly. An optional auto-off timer clears the enable after a programmable on-time.

Parameters:
DEBOUNCE_CYC, 1_000_000, consecutive stable sys_clk cycles needed to qualify a press or release (20 ms at 50 MHz); legal range >= 2
TIMEOUT_CYC, 500_000_000, flash on-time before auto-off (10 s at 50 MHz); 0 disables auto-off

Ports:
sys_clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
key_n  input  1  raw push button, asynchronous, active-low (0 = pressed)
press_pulse  output  1  one-cycle strobe per debounced press
flash_en  output  1  level enable to the flash stage; 1 = flashing

Behaviour:
- Single clock domain, sys_clk. Reset is synchronous and active-high: all state updates only on the sys_clk rising edge while rst = 1.
- Reset values:
  - sync flops = 1 (released)
  - FSM = IDLE
  - debounce counter = 0
  - timeout counter = 0
  - press_pulse = 0
  - flash_en = 0
- Synchroniser: key_n passes through a 2-flop chain; key_s is the second flop. Only key_s is used downstream.
- Debounce counter width is $clog2(DEBOUNCE_CYC).
- FSM states:
  - IDLE: if key_s = 0, go to DB_PRESS and clear cnt.
  - DB_PRESS:
    - key_s = 1 (bounce): go to IDLE, clear cnt.
    - else if cnt = DEBOUNCE_CYC-1: go to HELD and set press_pulse = 1 for that one cycle.
    - else: cnt++.
  - HELD: if key_s = 1, go to DB_RELEASE and clear cnt. press_pulse = 0.
  - DB_RELEASE:
    - key_s = 0: go to HELD, clear cnt.
    - else if cnt = DEBOUNCE_CYC-1: go to IDLE.
    - else: cnt++.
    - Releases never generate a pulse.
- press_pulse latency: if key_n falls before edge 0 and stays low, press_pulse is high exactly in the cycle after edge DEBOUNCE_CYC+3. It lasts one cycle only, regardless of hold duration.
- flash_en toggles on the same edge that press_pulse is registered high.
- Timeout counter, width $clog2(TIMEOUT_CYC+1):
  - Counts while flash_en = 1 and TIMEOUT_CYC != 0.
  - When it reaches TIMEOUT_CYC-1, flash_en <= 0 and the counter clears. flash_en is therefore high for exactly TIMEOUT_CYC cycles absent a press.
  - Counter clears whenever flash_en = 0 and on every toggle.
- Simultaneous timeout expiry and press_pulse: flash_en <= 0 (no re-enable), counter clears.
- Reset mid-operation: all state returns to reset values on the next edge, with no pulse in that cycle. A key held through reset release is treated as a new press: after the sync re-fills and a full debounce, one press_pulse and a toggle to 1 follow.
- No combinational path from key_n to any output. Both outputs are registered.

Decomposition:
- Shared package key_flash_pkg holds:
  - the FSM state enum (IDLE, DB_PRESS, HELD, DB_RELEASE)
  - default constants CLK_HZ = 50_000_000, DEBOUNCE_MS = 20, TIMEOUT_S = 10
- Sub-module key_debounce contains the synchroniser, FSM and debounce counter, and outputs press_pulse.
- key_flash_ctrl instantiates key_debounce and holds the toggle register and timeout counter.

Test Plan:
Bench parameters: DEBOUNCE_CYC = 8, TIMEOUT_CYC = 100.
1. Reset: hold rst = 1 for 3 cycles with key_n = 1 -> press_pulse = 0 and flash_en = 0 in every reset cycle and after reset is released.
2. Clean press: key_n = 0 before edge 0, held 30 cycles, then released -> press_pulse = 1 only in the cycle after edge 11. flash_en rises at edge 11 and stays 1. No pulse on release.
3. Bounce rejection, press:
   - Stimulus: key_n low for 5 cycles, high for 2, then low for 30.
   - Response: no pulse during the first low burst. Exactly one pulse, occurring 11 edges after the final falling edge.
4. Toggle off and release bounce:
   - Stimulus: with flash_en = 1, a second clean press, then a release with 3 glitches of 2 cycles each.
   - Response: flash_en = 0 at the pulse edge, and no further pulses.
5. Auto-off: one clean press, then idle -> flash_en high for exactly 100 cycles, then 0. Repeat with the second press landing on the expiry edge -> flash_en = 0 afterwards.
6. Reset mid-debounce:
   - Stimulus: assert rst for 1 cycle at DB_PRESS cnt = 5, with key_n held low.
   - Response: press_pulse and flash_en both 0 during reset. One pulse exactly 11 edges after rst deasserts, and flash_en = 1.
